// File: rtl/srl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srl_pkg
// Description : Shared constants and state encodings for the SRL-based CAM
//               storage array and its fill sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package srl_pkg;

  // Default geometry of the CAM storage array, shared with the array itself
  localparam int unsigned SRL_DEPTH_DEF = 32;
  localparam int unsigned NUM_SRL_DEF   = 8;

  // Fill sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // Number of accepted beats needed to fill the whole array
  function automatic int unsigned fill_beats(input int unsigned num_srl,
                                             input int unsigned srl_depth);
    return num_srl * srl_depth;
  endfunction

endpackage : srl_pkg
`default_nettype wire

// File: rtl/srl_fill_seq_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Up-counter with synchronous clear that returns to zero after
//               reaching MAX. 'wrap' flags the enabled count at MAX so it can
//               cascade into the next counter stage.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  logic [WIDTH-1:0] r_q;
  logic             w_at_max;

  // Explicit terminal compare so non-power-of-two ranges never overshoot
  assign w_at_max = (r_q == WIDTH'(MAX));
  assign wrap     = en & w_at_max;
  assign q        = r_q;

  // Count on enable; clear has priority over counting, reset over both
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_at_max ? '0 : (r_q + WIDTH'(1));
    end
  end

endmodule : wrap_counter
`default_nettype wire

// File: rtl/srl_fill_seq.sv
`default_nettype none
// ============================================================================
// Module      : srl_fill_seq
// Description : Fill sequencer for the SRL-based CAM storage array. Steps a
//               write stream across NUM_SRL banks of SRL_DEPTH entries,
//               driving bank select and per-beat shift enable, with stall,
//               abort, a one-cycle done pulse and a sticky full level.
// Revision    : 1.0 - initial release
// ============================================================================
module srl_fill_seq
  import srl_pkg::*;
#(
  parameter int unsigned SRL_DEPTH = SRL_DEPTH_DEF,
  parameter int unsigned NUM_SRL   = NUM_SRL_DEF,
  parameter int unsigned SEL_W     = $clog2(NUM_SRL),
  parameter int unsigned IDX_W     = $clog2(SRL_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             wr_valid,
  input  logic             abort,
  output logic [SEL_W-1:0] sel,
  output logic [IDX_W-1:0] bit_idx,
  output logic             srl_ce,
  output logic             busy,
  output logic             done,
  output logic             full
);

  state_t r_state;
  logic   r_busy;
  logic   r_done;
  logic   r_full;

  logic   w_in_fill;
  logic   w_can_start;
  logic   w_ce;
  logic   w_clr;
  logic   w_sel_en;
  logic   w_bit_wrap;
  logic   w_sel_wrap;
  logic   w_final_beat;

  // Shift enable is combinational so the bank sees the beat in its own cycle;
  // abort wins over a coincident write beat.
  assign w_in_fill   = (r_state == ST_FILL);
  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_FULL);
  assign w_ce        = w_in_fill & wr_valid & ~abort;

  // Counters restart on every accepted start and on any abort; the final beat
  // brings both back to zero through their own wrap paths.
  assign w_clr        = abort | (w_can_start & start);
  assign w_sel_en     = w_ce & w_bit_wrap;
  assign w_final_beat = w_sel_wrap;

  // Entry index within the current bank
  wrap_counter #(
    .WIDTH (IDX_W),
    .MAX   (SRL_DEPTH - 1)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_ce),
    .q     (bit_idx),
    .wrap  (w_bit_wrap)
  );

  // Bank select, advanced by the beat that completes a bank
  wrap_counter #(
    .WIDTH (SEL_W),
    .MAX   (NUM_SRL - 1)
  ) u_sel_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_sel_en),
    .q     (sel),
    .wrap  (w_sel_wrap)
  );

  // Sequencer state and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state <= ST_FILL;
            r_busy  <= 1'b1;
          end
        end
        ST_FILL: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_final_beat) begin
            r_state <= ST_FULL;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_full  <= 1'b1;
          end
        end
        ST_FULL: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_full  <= 1'b0;
          end else if (start) begin
            r_state <= ST_FILL;
            r_busy  <= 1'b1;
            r_full  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_full  <= 1'b0;
        end
      endcase
    end
  end

  assign srl_ce = w_ce;
  assign busy   = r_busy;
  assign done   = r_done;
  assign full   = r_full;

endmodule : srl_fill_seq
`default_nettype wire

// File: tb/tb_srl_fill_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_srl_fill_seq
// Description : Directed self-checking bench for srl_fill_seq, default
//               geometry plus a 5x4 non-power-of-two instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srl_fill_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic       wr_valid;
  logic       abort;
  logic [2:0] sel;
  logic [4:0] bit_idx;
  logic       srl_ce;
  logic       busy;
  logic       done;
  logic       full;

  logic       s5_start;
  logic       s5_wr;
  logic       s5_abort;
  logic [2:0] sel5;
  logic [1:0] idx5;
  logic       ce5;
  logic       busy5;
  logic       done5;
  logic       full5;

  int n_checks = 0;
  int n_err    = 0;
  int beats    = 0;
  int fill_cycles = 0;

  srl_fill_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .wr_valid (wr_valid),
    .abort    (abort),
    .sel      (sel),
    .bit_idx  (bit_idx),
    .srl_ce   (srl_ce),
    .busy     (busy),
    .done     (done),
    .full     (full)
  );

  srl_fill_seq #(
    .SRL_DEPTH (4),
    .NUM_SRL   (5)
  ) dut5 (
    .clk      (clk),
    .reset    (reset),
    .start    (s5_start),
    .wr_valid (s5_wr),
    .abort    (s5_abort),
    .sel      (sel5),
    .bit_idx  (idx5),
    .srl_ce   (ce5),
    .busy     (busy5),
    .done     (done5),
    .full     (full5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run the default DUT in FILL until 'target' beats have been accepted,
  // checking counters against the beat count every cycle.
  task automatic advance(input int target, input int duty_pct);
    int guard;
    guard = 0;
    while (beats < target && guard < 4000) begin
      chk("sel", sel, beats / 32);
      chk("bit_idx", bit_idx, beats % 32);
      chk("busy_fill", busy, 1);
      chk("done_fill", done, 0);
      wr_valid = ($urandom_range(0, 99) < duty_pct);
      #1;
      chk("srl_ce", srl_ce, wr_valid);
      if (wr_valid) beats++;
      tick();
      guard++;
      fill_cycles++;
    end
    chk("advance_bound", (guard < 4000), 1);
  endtask

  // Completion pulse on the edge after the final beat, then held full
  task automatic check_done();
    chk("done_pulse", done, 1);
    chk("full_rise", full, 1);
    chk("busy_drop", busy, 0);
    chk("sel_end", sel, 0);
    chk("idx_end", bit_idx, 0);
    wr_valid = 1'b1;
    #1;
    chk("ce_in_full", srl_ce, 0);
    tick();
    chk("done_clear", done, 0);
    chk("full_hold", full, 1);
    chk("busy_full", busy, 0);
  endtask

  initial begin
    int b5;
    int g5;
    reset = 1'b1; start = 1'b0; wr_valid = 1'b0; abort = 1'b0;
    s5_start = 1'b0; s5_wr = 1'b0; s5_abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state and idle behaviour
    chk("rst_sel", sel, 0);
    chk("rst_idx", bit_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);
    wr_valid = 1'b1;
    #1;
    chk("ce_idle", srl_ce, 0);

    // Uninterrupted fill: done 257 edges after the start edge
    start = 1'b1;
    tick();
    chk("start_busy", busy, 1);
    chk("start_full", full, 0);
    start = 1'b0;
    beats = 0; fill_cycles = 0;
    advance(256, 100);
    chk("fill_cycles", fill_cycles, 256);
    check_done();

    // Refill from FULL with start held high during the fill
    start = 1'b1;
    tick();
    chk("refill_full", full, 0);
    chk("refill_busy", busy, 1);
    beats = 0; fill_cycles = 0;
    advance(20, 100);
    start = 1'b0;
    advance(256, 100);
    chk("refill_cycles", fill_cycles, 256);
    check_done();

    // Stalled fill, roughly 40 % write duty
    start = 1'b1;
    tick();
    start = 1'b0;
    beats = 0;
    advance(256, 40);
    chk("stall_beats", beats, 256);
    check_done();

    // Abort from FULL
    abort = 1'b1;
    tick();
    chk("abort_full_full", full, 0);
    chk("abort_full_busy", busy, 0);
    abort = 1'b0;

    // Abort mid-fill at beat 100 with a coincident write beat
    start = 1'b1;
    tick();
    start = 1'b0;
    beats = 0;
    advance(100, 100);
    chk("abort_pre_sel", sel, 3);
    chk("abort_pre_idx", bit_idx, 4);
    abort = 1'b1; wr_valid = 1'b1;
    #1;
    chk("abort_ce", srl_ce, 0);
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sel", sel, 0);
    chk("abort_idx", bit_idx, 0);
    chk("abort_done", done, 0);
    chk("abort_fullo", full, 0);
    tick();
    chk("abort_done2", done, 0);
    chk("abort_ce_idle", srl_ce, 0);

    // Reset mid-fill at beat 200, then a clean refill
    start = 1'b1;
    tick();
    start = 1'b0;
    beats = 0;
    advance(200, 100);
    chk("rst_pre_sel", sel, 6);
    chk("rst_pre_idx", bit_idx, 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstm_sel", sel, 0);
    chk("rstm_idx", bit_idx, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_done", done, 0);
    chk("rstm_full", full, 0);
    tick();
    chk("rstm_done2", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    beats = 0; fill_cycles = 0;
    advance(256, 100);
    chk("rstm_cycles", fill_cycles, 256);
    check_done();
    wr_valid = 1'b0;

    // Non-power-of-two geometry: 5 banks of 4 entries
    chk("d5_rst_sel", sel5, 0);
    chk("d5_rst_full", full5, 0);
    s5_start = 1'b1; s5_wr = 1'b1;
    tick();
    s5_start = 1'b0;
    chk("d5_busy", busy5, 1);
    b5 = 0; g5 = 0;
    while (b5 < 20 && g5 < 100) begin
      chk("d5_sel", sel5, b5 / 4);
      chk("d5_idx", idx5, b5 % 4);
      chk("d5_done", done5, 0);
      chk("d5_ce", ce5, 1);
      b5++;
      g5++;
      tick();
    end
    chk("d5_cycles", g5, 20);
    chk("d5_done_pulse", done5, 1);
    chk("d5_full", full5, 1);
    chk("d5_sel_end", sel5, 0);
    chk("d5_busy_end", busy5, 0);
    tick();
    chk("d5_done_clear", done5, 0);
    chk("d5_ce_full", ce5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_srl_fill_seq
`default_nettype wire

// File: doc/srl_fill_seq.md
# srl_fill_seq

Parametrised fill sequencer for the SRL-based CAM storage array. It steps a write stream across `NUM_SRL` shift-register banks of `SRL_DEPTH` entries each. It drives the bank select and a per-beat shift enable, and reports completion with a one-cycle `done` pulse and a sticky `full` level. Wait-state stalls and explicit abort are supported; the select path sits between the CAM write front-end and the SRL bank-select mux.

## Interface
- `SRL_DEPTH`, default 32: entries per SRL bank; power of two, ≥2.
- `NUM_SRL`, default 8: number of SRL banks; ≥2, need not be a power of two.
- `SEL_W`, default `$clog2(NUM_SRL)`: width of `sel`.
- `IDX_W`, default `$clog2(SRL_DEPTH)`: width of `bit_idx`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a fill; sampled only in IDLE or FULL.
- `wr_valid`  in  1  write beat available this cycle; low = stall.
- `abort`  in  1  cancel the fill in progress.
- `sel`  out  SEL_W  bank currently being filled.
- `bit_idx`  out  IDX_W  entry index within the current bank.
- `srl_ce`  out  1  shift enable for bank `sel`; combinational, equals (state==FILL) & wr_valid & ~abort.
- `busy`  out  1  high in FILL.
- `done`  out  1  one-cycle pulse on the cycle after the final beat.
- `full`  out  1  level: all banks filled; held until next start, abort or reset.

## Operation
- States: IDLE, FILL, FULL.
- IDLE: if start & ~abort, go to FILL and clear sel/bit_idx to 0. Otherwise stay in IDLE.
- FILL, ordinary beat: each cycle with srl_ce=1 is one accepted beat.
  - bit_idx increments by 1.
  - At bit_idx==SRL_DEPTH-1, bit_idx wraps to 0 and sel increments by 1.
- FILL, final beat: the beat at sel==NUM_SRL-1 and bit_idx==SRL_DEPTH-1.
  - Next state is FULL.
  - sel and bit_idx return to 0.
  - done pulses and full rises.
- FILL, stall: wr_valid=0 holds all counters and state. Stalls do not restart the fill.
- FILL, start: ignored.
- FILL, abort: abort=1 goes to IDLE, clears counters and suppresses srl_ce. abort beats wr_valid in the same cycle. No done pulse.
- FULL: full=1 and srl_ce=0.
  - start & ~abort re-enters FILL with counters cleared, and full drops.
  - abort goes to IDLE and full drops.
- Counter arithmetic: bit_idx wraps naturally (power of two). sel is compared explicitly against NUM_SRL-1 and never exceeds it.
- Reset: state=IDLE; sel=0, bit_idx=0, busy=0, done=0, full=0.
- Reset mid-fill drops the partial fill with no done pulse.
- reset has priority over all inputs.

## Timing
- start in IDLE at edge N: busy=1 at N+1. The first beat can be accepted in cycle N+1.
- srl_ce has zero latency from wr_valid; all other outputs are registered.
- Fill length is exactly NUM_SRL×SRL_DEPTH accepted beats, 256 at defaults, independent of stall count.
- Last beat accepted in cycle M: at M+1, done=1, full=1, busy=0. At M+2, done=0.
- With no stalls, start at edge N gives done at N+1+NUM_SRL×SRL_DEPTH.
- sel changes on the edge after the beat with bit_idx=SRL_DEPTH-1. The bank mux sees the new select for the next beat.

## Structure
- Shared package `srl_pkg`: state encodings `ST_IDLE`, `ST_FILL`, `ST_FULL` (2-bit), and default `SRL_DEPTH`/`NUM_SRL` constants shared with the CAM array.
- One natural sub-module, `wrap_counter`: parameters `WIDTH` and `MAX`; ports `clk`, `reset`, `clr`, `en`; outputs `q` and `wrap` (en & q==MAX). It is instantiated twice, once for bit_idx and once for sel. The FSM is glue around the two counters.

## Test plan
- **Uninterrupted fill:** defaults, reset, then start and wr_valid held high → sel steps 0..7 every 32 beats; done pulses once, 257 cycles after start; full=1 afterwards; srl_ce count = 256.
- **Stalled fill:** wr_valid toggled pseudo-randomly with 40 % duty → exactly 256 srl_ce pulses; sel/bit_idx never change on stall cycles; done comes after the 256th beat.
- **Abort mid-fill:** abort at beat 100 (sel=3, bit_idx=4), with wr_valid=1 in the same cycle → no srl_ce that cycle; IDLE next cycle; counters 0; no done; full=0.
- **Reset mid-fill:** reset at beat 200 → all outputs at reset values next cycle; a subsequent start refills from sel=0, bit_idx=0.
- **Refill from FULL:** start in FULL → full=0 and busy=1 next cycle. start asserted again during FILL is ignored, and the count is unaffected.
- **Non-power-of-two banks:** NUM_SRL=5, SRL_DEPTH=4 → sel sequence 0..4, never 5..7; done after 20 beats.
